// File: rtl/dbreak_arb.sv
// Data-break (DMA) arbiter and sequencer: shares the single memory break cycle among NREQ devices.
// Define DBRK_ROUND_ROBIN_EN for rotating priority; default is fixed priority, index 0 highest.
module dbreak_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned IDXW    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [NREQ-1:0]    brk_req,
    input  logic [NREQ-1:0]    brk_to_mem,
    input  logic [15*NREQ-1:0] brk_addr,
    input  logic [12*NREQ-1:0] brk_wdata,
    input  logic               cpu_slot,
    input  logic               break_done,
    input  logic [11:0]        dmaDIN,
    output logic               data_break,
    output logic               to_mem,
    output logic [14:0]        dmaAddr,
    output logic [11:0]        dmaDOUT,
    output logic [11:0]        brk_rdata,
    output logic [NREQ-1:0]    brk_ack,
    output logic [NREQ-1:0]    brk_err,
    output logic               break_in_prog,
    output logic [IDXW-1:0]    grant_idx
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitSlot,
        StBreak,
        StDone
    } state_e;

    localparam logic [7:0] TmoLimit = 8'(TIMEOUT);

    state_e          state_q;
    logic [7:0]      tmo_cnt_q;
    logic            any_req;
    logic [IDXW-1:0] win_idx;

    assign any_req = |brk_req;

`ifdef DBRK_ROUND_ROBIN_EN
    logic [IDXW-1:0] last_q;

    // Scan downwards so the requester closest after the last grant is assigned last and wins.
    always_comb begin
        win_idx = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            if (brk_req[(int'(last_q) + k) % int'(NREQ)]) begin
                win_idx = IDXW'((int'(last_q) + k) % int'(NREQ));
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (brk_req[i]) begin
                win_idx = IDXW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            tmo_cnt_q     <= '0;
            data_break    <= 1'b0;
            to_mem        <= 1'b0;
            dmaAddr       <= '0;
            dmaDOUT       <= '0;
            brk_rdata     <= '0;
            brk_ack       <= '0;
            brk_err       <= '0;
            break_in_prog <= 1'b0;
            grant_idx     <= '0;
`ifdef DBRK_ROUND_ROBIN_EN
            last_q        <= IDXW'(NREQ - 1);
`endif
        end else begin
            brk_ack <= '0;
            brk_err <= '0;
            unique case (state_q)
                StIdle: begin
                    if (any_req && !clear) begin
                        grant_idx     <= win_idx;
                        to_mem        <= brk_to_mem[win_idx];
                        dmaAddr       <= brk_addr[15*win_idx +: 15];
                        dmaDOUT       <= brk_wdata[12*win_idx +: 12];
                        break_in_prog <= 1'b1;
                        state_q       <= StWaitSlot;
                    end
                end
                StWaitSlot: begin
                    // Clear wins over a coincident slot: nothing has touched memory yet.
                    if (clear) begin
                        break_in_prog <= 1'b0;
                        state_q       <= StIdle;
                    end else if (cpu_slot) begin
                        data_break <= 1'b1;
                        tmo_cnt_q  <= '0;
                        state_q    <= StBreak;
                    end
                end
                StBreak: begin
                    if (break_done) begin
                        if (!to_mem) begin
                            brk_rdata <= dmaDIN;
                        end
                        data_break         <= 1'b0;
                        brk_ack[grant_idx] <= 1'b1;
                        break_in_prog      <= 1'b0;
                        state_q            <= StDone;
`ifdef DBRK_ROUND_ROBIN_EN
                        last_q             <= grant_idx;
`endif
                    end else if (tmo_cnt_q == TmoLimit) begin
                        data_break         <= 1'b0;
                        brk_err[grant_idx] <= 1'b1;
                        break_in_prog      <= 1'b0;
                        state_q            <= StIdle;
`ifdef DBRK_ROUND_ROBIN_EN
                        last_q             <= grant_idx;
`endif
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    // Ack is visible for this one cycle; requesters drop brk_req before next IDLE.
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(brk_ack));
    a_err_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(brk_err));
    a_ack_err_excl: assert property (@(posedge clk) disable iff (reset)
        !((|brk_ack) && (|brk_err)));
    a_brk_in_prog: assert property (@(posedge clk) disable iff (reset)
        data_break |-> break_in_prog);
    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (data_break && $past(data_break)) |-> ($stable(dmaAddr) && $stable(dmaDOUT)
        && $stable(to_mem)));

endmodule

// File: tb/tb_dbreak_arb.sv
// Self-checking bench for dbreak_arb: directed vector table, corner sequences, randomized traffic.
`timescale 1ns/1ps
module tb_dbreak_arb;

    localparam int NREQ   = 2;
    localparam int TMO    = 255;
    localparam int TMO_HI = TMO + 1;  // counter runs 0..TIMEOUT inclusive while data_break is high

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [1:0]  brk_req;
    logic [1:0]  brk_to_mem;
    logic [29:0] brk_addr;
    logic [23:0] brk_wdata;
    logic        cpu_slot;
    logic        break_done;
    logic [11:0] dmaDIN;
    logic        data_break;
    logic        to_mem;
    logic [14:0] dmaAddr;
    logic [11:0] dmaDOUT;
    logic [11:0] brk_rdata;
    logic [1:0]  brk_ack;
    logic [1:0]  brk_err;
    logic        break_in_prog;
    logic [0:0]  grant_idx;

    always #5 clk = ~clk;

    dbreak_arb #(.NREQ(NREQ), .TIMEOUT(TMO), .IDXW(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .brk_req(brk_req), .brk_to_mem(brk_to_mem),
        .brk_addr(brk_addr), .brk_wdata(brk_wdata), .cpu_slot(cpu_slot),
        .break_done(break_done), .dmaDIN(dmaDIN), .data_break(data_break), .to_mem(to_mem),
        .dmaAddr(dmaAddr), .dmaDOUT(dmaDOUT), .brk_rdata(brk_rdata), .brk_ack(brk_ack),
        .brk_err(brk_err), .break_in_prog(break_in_prog), .grant_idx(grant_idx)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: last granted requester and last value read from memory.
    int          m_last  = NREQ - 1;
    logic [11:0] m_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int pick(input logic [1:0] req);
`ifdef DBRK_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return 0;
`else
        return req[0] ? 0 : 1;
`endif
    endfunction

    // One full break transaction from IDLE, checking every cycle of the handshake.
    task automatic do_break(input string tag, input logic [1:0] req, input logic [1:0] tm,
                            input logic [29:0] addr, input logic [23:0] wdata,
                            input logic [11:0] din, input int slot_dly, input int done_dly,
                            input int exp_idx, input logic [11:0] exp_rdata,
                            input logic [1:0] req_after, input bit clr_brk, input bit noise);
        int hi;
        brk_req    = req;
        brk_to_mem = tm;
        brk_addr   = addr;
        brk_wdata  = wdata;
        cpu_slot   = 1'b0;
        clear      = 1'b0;
        break_done = 1'b0;
        @(negedge clk);
        chk({tag, " grant bip"}, break_in_prog, 1);
        chk({tag, " grant idx"}, grant_idx, exp_idx);
        chk({tag, " grant addr"}, dmaAddr, addr[15*exp_idx +: 15]);
        chk({tag, " grant dout"}, dmaDOUT, wdata[12*exp_idx +: 12]);
        chk({tag, " grant to_mem"}, to_mem, tm[exp_idx]);
        chk({tag, " grant db"}, data_break, 0);
        // Corrupt the live inputs: outputs must keep the latched copy.
        brk_addr   = ~addr;
        brk_wdata  = ~wdata;
        brk_to_mem = ~tm;
        repeat (slot_dly) begin
            break_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            chk({tag, " wait db"}, data_break, 0);
        end
        cpu_slot   = 1'b1;
        break_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        break_done = 1'b0;
        cpu_slot   = 1'b0;
        chk({tag, " db rise"}, data_break, 1);
        if (clr_brk) clear = 1'b1;
        hi = 1;
        repeat (done_dly) begin
            cpu_slot = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (data_break) hi++;
        end
        chk({tag, " db cycles"}, hi, done_dly + 1);
        clear      = 1'b0;
        break_done = 1'b1;
        dmaDIN     = din;
        @(negedge clk);
        break_done = 1'b0;
        dmaDIN     = ~din;
        chk({tag, " done db"}, data_break, 0);
        chk({tag, " ack"}, brk_ack, 1 << exp_idx);
        chk({tag, " err"}, brk_err, 0);
        chk({tag, " done bip"}, break_in_prog, 0);
        chk({tag, " rdata"}, brk_rdata, exp_rdata);
        chk({tag, " held addr"}, dmaAddr, addr[15*exp_idx +: 15]);
        chk({tag, " held dout"}, dmaDOUT, wdata[12*exp_idx +: 12]);
        chk({tag, " held idx"}, grant_idx, exp_idx);
        brk_req = req_after;
        @(negedge clk);
        chk({tag, " ack pulse"}, brk_ack, 0);
        chk({tag, " idle bip"}, break_in_prog, 0);
        m_last  = exp_idx;
        m_rdata = exp_rdata;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  tm;
        logic [29:0] addr;
        logic [23:0] wdata;
        logic [11:0] din;
        int          slot_dly;
        int          done_dly;
        bit          clr_brk;
        int          exp_idx;
        logic [11:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          hi;
        int          idx;
        logic [1:0]  rq;
        logic [1:0]  tm;
        logic [29:0] a;
        logic [23:0] w;
        logic [11:0] d;

        vecs[0] = '{2'b01, 2'b10, {15'o00777, 15'o12345}, {12'o0000, 12'o1111}, 12'o7070,
                    0, 2, 1'b0, 0, 12'o7070};
        vecs[1] = '{2'b10, 2'b10, {15'o54321, 15'o01234}, {12'o4321, 12'o5670}, 12'o5555,
                    1, 0, 1'b0, 1, 12'o7070};
        vecs[2] = '{2'b10, 2'b01, {15'o77777, 15'o00000}, {12'o0000, 12'o7777}, 12'o1234,
                    3, 1, 1'b1, 1, 12'o1234};
        vecs[3] = '{2'b01, 2'b01, {15'o00001, 15'o00000}, {12'o0000, 12'o7777}, 12'o6543,
                    0, 0, 1'b0, 0, 12'o1234};
        vecs[4] = '{2'b01, 2'b00, {15'o00000, 15'o40000}, {12'o5252, 12'o2525}, 12'o0001,
                    2, TMO, 1'b0, 0, 12'o0001};

        reset = 1'b1; clear = 1'b0; brk_req = '0; brk_to_mem = '0; brk_addr = '0;
        brk_wdata = '0; cpu_slot = 1'b0; break_done = 1'b0; dmaDIN = '0;
        repeat (2) @(negedge clk);
        chk("reset db", data_break, 0);
        chk("reset bip", break_in_prog, 0);
        chk("reset to_mem", to_mem, 0);
        chk("reset addr", dmaAddr, 0);
        chk("reset dout", dmaDOUT, 0);
        chk("reset rdata", brk_rdata, 0);
        chk("reset ack", brk_ack, 0);
        chk("reset err", brk_err, 0);
        chk("reset idx", grant_idx, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_break($sformatf("vec%0d", i), vecs[i].req, vecs[i].tm, vecs[i].addr,
                     vecs[i].wdata, vecs[i].din, vecs[i].slot_dly, vecs[i].done_dly,
                     vecs[i].exp_idx, vecs[i].exp_rdata, 2'b00, vecs[i].clr_brk, 1'b0);
        end

        // Both requesters held.
`ifdef DBRK_ROUND_ROBIN_EN
        for (int g = 0; g < 4; g++) begin
            do_break($sformatf("rr%0d", g), 2'b11, 2'b11, {15'o22222, 15'o11111},
                     {12'o2222, 12'o1111}, 12'o0707, 0, 0, pick(2'b11), m_rdata,
                     (g == 3) ? 2'b00 : 2'b11, 1'b0, 1'b0);
        end
`else
        do_break("prio first", 2'b11, 2'b11, {15'o22222, 15'o11111}, {12'o2222, 12'o1111},
                 12'o0707, 0, 0, 0, m_rdata, 2'b10, 1'b0, 1'b0);
        do_break("prio second", 2'b10, 2'b11, {15'o22222, 15'o11111}, {12'o2222, 12'o1111},
                 12'o0707, 0, 0, 1, m_rdata, 2'b00, 1'b0, 1'b0);
`endif

        // Clear blocks arbitration in IDLE and aborts WAIT_SLOT.
        brk_req = 2'b01; brk_to_mem = 2'b00; brk_addr = 30'h1234567; clear = 1'b1;
        cpu_slot = 1'b0;
        @(negedge clk);
        chk("clear idle bip", break_in_prog, 0);
        clear = 1'b0;
        @(negedge clk);
        chk("clear grant bip", break_in_prog, 1);
        clear = 1'b1;
        @(negedge clk);
        chk("clear abort bip", break_in_prog, 0);
        chk("clear abort db", data_break, 0);
        chk("clear abort ack", brk_ack, 0);
        chk("clear abort err", brk_err, 0);
        clear = 1'b0; brk_req = 2'b00;
        @(negedge clk);
        chk("clear after ack", brk_ack, 0);
        chk("clear after db", data_break, 0);

        // Timeout: no break_done ever arrives.
        brk_req = 2'b01; brk_to_mem = 2'b00; cpu_slot = 1'b1;
        @(negedge clk);
        chk("tmo bip", break_in_prog, 1);
        @(negedge clk);
        chk("tmo db rise", data_break, 1);
        hi = 1;
        while (hi < 400) begin
            @(negedge clk);
            if (!data_break) break;
            hi++;
        end
        chk("tmo db cycles", hi, TMO_HI);
        chk("tmo err", brk_err, 2'b01);
        chk("tmo ack", brk_ack, 0);
        chk("tmo bip drop", break_in_prog, 0);
        brk_req = 2'b00; cpu_slot = 1'b0;
        @(negedge clk);
        chk("tmo err pulse", brk_err, 0);
        chk("tmo idle bip", break_in_prog, 0);
        m_last = 0;

        // Asynchronous reset in the middle of BREAK.
        brk_req = 2'b10; brk_to_mem = 2'b00; brk_addr = {15'o11111, 15'o22222}; cpu_slot = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst pre db", data_break, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst async db", data_break, 0);
        chk("rst async bip", break_in_prog, 0);
        chk("rst async addr", dmaAddr, 0);
        chk("rst async idx", grant_idx, 0);
        @(negedge clk);
        reset = 1'b0; brk_req = 2'b00; cpu_slot = 1'b0;
        m_last = NREQ - 1; m_rdata = '0;
        @(negedge clk);
        chk("rst no ack", brk_ack, 0);
        chk("rst no err", brk_err, 0);
        chk("rst rdata", brk_rdata, 0);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            rq  = 2'($urandom_range(1, 3));
            tm  = 2'($urandom);
            a   = 30'($urandom);
            w   = 24'($urandom);
            d   = 12'($urandom);
            idx = pick(rq);
            do_break($sformatf("rand%0d", t), rq, tm, a, w, d, $urandom_range(0, 3),
                     $urandom_range(0, 4), idx, tm[idx] ? m_rdata : d, 2'b00,
                     1'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
